// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug access controller.
//   dbg_state_e    : controller FSM states
//   DBG_*          : response error codes carried on resp_err
//   DBG_SPACE_BIT  : position of the GPR/CSR space select bit in the debug
//                    address for the default CSR address width
package dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_GPR  = 3'd2,
    S_CSR  = 3'd3,
    S_RESP = 3'd4
  } dbg_state_e;

  localparam logic [1:0] DBG_OK       = 2'd0;
  localparam logic [1:0] DBG_EBADADDR = 2'd1;
  localparam logic [1:0] DBG_EHALT    = 2'd2;
  localparam logic [1:0] DBG_ECSR     = 2'd3;

  localparam int unsigned DBG_CSR_AW_DEF = 12;
  // The space select bit always sits directly above the CSR address field.
  localparam int unsigned DBG_SPACE_BIT  = DBG_CSR_AW_DEF;

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Saturating wait counter shared by the halt wait and the CSR wait.
//   clk, reset   : clock, asynchronous active-high reset
//   i_clear      : synchronous clear (wins over i_en)
//   i_en         : count this cycle
//   o_expired_c  : combinational; high in the enabled cycle that brings the
//                  count to the limit 2^TMO_W-1, i.e. the last cycle of waiting
module dbg_timeout_ctr #(
  parameter int unsigned TMO_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired_c
);

  localparam logic [TMO_W-1:0] LIMIT = '1;

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_expired_c = i_en && !i_clear && (r_cnt == (LIMIT - TMO_W'(1)));

endmodule

// File: rtl/debug_access_ctrl.sv
// Debug access controller: serialises external debug read/write requests into
// halt-protected accesses on the core's GPR and CSR debug ports.
//   clk, reset            : clock, asynchronous active-high reset
//   debug_enable          : block enable; when low the FSM parks in IDLE
//   req_*                 : request channel (valid/ready), addr MSB selects CSR
//   resp_*                : response channel (valid/ready) with error code
//   halt_req / cpu_halted : halt handshake with the core
//   rf_*                  : GPR debug port (single-cycle write strobe)
//   csr_*                 : CSR debug port (req held until ack)
// Build option: define DBG_AUTO_RESUME_EN to release halt_req on every
// response handshake; otherwise halt_req is sticky until debug_enable drops.
module debug_access_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CSR_AW = DBG_CSR_AW_DEF,
  parameter int unsigned TMO_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    debug_enable,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CSR_AW:0]         req_addr,
  input  logic                    req_write,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_rdata,
  output logic [1:0]              resp_err,
  output logic                    halt_req,
  input  logic                    cpu_halted,
  output logic [$clog2(NREG)-1:0] rf_addr,
  output logic                    rf_we,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic [XLEN-1:0]         rf_rdata,
  output logic                    csr_req,
  output logic                    csr_we,
  output logic [CSR_AW-1:0]       csr_addr,
  output logic [XLEN-1:0]         csr_wdata,
  input  logic [XLEN-1:0]         csr_rdata,
  input  logic                    csr_ack
);

  localparam int unsigned RW      = $clog2(NREG);
  localparam int unsigned SEL_BIT = CSR_AW;

  dbg_state_e        r_state;
  logic              r_req_ready;
  logic              r_write;
  logic              r_csr;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_resp_rdata;
  logic [1:0]        r_resp_err;
  logic              r_halt_req;
  logic [RW-1:0]     r_rf_addr;
  logic              r_rf_we;
  logic [XLEN-1:0]   r_rf_wdata;
  logic              r_csr_req;
  logic              r_csr_we;
  logic [CSR_AW-1:0] r_csr_addr;
  logic [XLEN-1:0]   r_csr_wdata;

  logic w_accept;
  logic w_req_csr;
  logic w_bad_addr;
  logic w_req_gpr_we;
  logic w_ctr_clr;
  logic w_ctr_en;
  logic w_expired;

  assign w_accept     = req_valid && r_req_ready;
  assign w_req_csr    = req_addr[SEL_BIT];
  // The whole field below the select bit is the GPR index, so out-of-range
  // indices are caught even when they alias a valid index in the low RW bits.
  assign w_bad_addr   = !w_req_csr && (32'(req_addr[CSR_AW-1:0]) >= NREG);
  // x0 is hardwired; a write to it is acknowledged but never strobed.
  assign w_req_gpr_we = req_write && (req_addr[RW-1:0] != '0);

  // One timer serves both waits; it restarts in IDLE and when the halt lands.
  assign w_ctr_clr = (r_state == S_IDLE) || ((r_state == S_HALT) && cpu_halted);
  assign w_ctr_en  = (r_state == S_HALT) || (r_state == S_CSR);

  dbg_timeout_ctr #(.TMO_W(TMO_W)) u_tmo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_ctr_clr),
    .i_en        (w_ctr_en),
    .o_expired_c (w_expired)
  );

  // Controller FSM with registered port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_write      <= 1'b0;
      r_csr        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= DBG_OK;
      r_halt_req   <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_we      <= 1'b0;
      r_rf_wdata   <= '0;
      r_csr_req    <= 1'b0;
      r_csr_we     <= 1'b0;
      r_csr_addr   <= '0;
      r_csr_wdata  <= '0;
    end else begin
      r_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= debug_enable;
          if (!debug_enable) r_halt_req <= 1'b0;
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_write      <= req_write;
            r_csr        <= w_req_csr;
            r_rf_addr    <= req_addr[RW-1:0];
            r_rf_wdata   <= req_wdata;
            r_csr_we     <= req_write;
            r_csr_addr   <= req_addr[CSR_AW-1:0];
            r_csr_wdata  <= req_wdata;
            r_resp_rdata <= '0;
            r_resp_err   <= DBG_OK;
            if (w_bad_addr) begin
              r_resp_err   <= DBG_EBADADDR;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_halt_req <= 1'b1;
              if (!cpu_halted) begin
                r_state <= S_HALT;
              end else if (w_req_csr) begin
                r_csr_req <= 1'b1;
                r_state   <= S_CSR;
              end else begin
                r_rf_we <= w_req_gpr_we;
                r_state <= S_GPR;
              end
            end
          end
        end
        S_HALT: begin
          if (cpu_halted) begin
            if (r_csr) begin
              r_csr_req <= 1'b1;
              r_state   <= S_CSR;
            end else begin
              r_rf_we <= r_write && (r_rf_addr != '0);
              r_state <= S_GPR;
            end
          end else if (w_expired) begin
            r_resp_err   <= DBG_EHALT;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_GPR: begin
          if (!r_write) r_resp_rdata <= rf_rdata;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_CSR: begin
          // An ack arriving in the final wait cycle still counts as success.
          if (csr_ack) begin
            if (!r_write) r_resp_rdata <= csr_rdata;
            r_csr_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (w_expired) begin
            r_csr_req    <= 1'b0;
            r_resp_err   <= DBG_ECSR;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= DBG_OK;
            r_req_ready  <= debug_enable;
            r_state      <= S_IDLE;
`ifdef DBG_AUTO_RESUME_EN
            r_halt_req   <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign halt_req   = r_halt_req;
  assign rf_addr    = r_rf_addr;
  assign rf_we      = r_rf_we;
  assign rf_wdata   = r_rf_wdata;
  assign csr_req    = r_csr_req;
  assign csr_we     = r_csr_we;
  assign csr_addr   = r_csr_addr;
  assign csr_wdata  = r_csr_wdata;

endmodule

// File: tb/tb_debug_access_ctrl.sv
// Scoreboard bench for debug_access_ctrl (NREG=16): stimulus pushes the
// expected response, a monitor compares every cycle a response is presented.
module tb_debug_access_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned CAW  = 12;
`ifdef DBG_AUTO_RESUME_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            debug_enable;
  logic            req_valid;
  logic            req_ready;
  logic [CAW:0]    req_addr;
  logic            req_write;
  logic [31:0]     req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_rdata;
  logic [1:0]      resp_err;
  logic            halt_req;
  logic            cpu_halted;
  logic [3:0]      rf_addr;
  logic            rf_we;
  logic [31:0]     rf_wdata;
  logic [31:0]     rf_rdata;
  logic            csr_req;
  logic            csr_we;
  logic [CAW-1:0]  csr_addr;
  logic [31:0]     csr_wdata;
  logic [31:0]     csr_rdata;
  logic            csr_ack;

  debug_access_ctrl #(.XLEN(XLEN), .NREG(NREG), .CSR_AW(CAW), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .debug_enable(debug_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .halt_req(halt_req), .cpu_halted(cpu_halted),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ack(csr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Core register file model.
  logic [31:0] gpr [16];
  assign rf_rdata = gpr[rf_addr];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) gpr[i] <= 32'h1000_0000 + 32'(i);
      gpr[5] <= 32'hDEADBEEF;
    end else if (rf_we) begin
      gpr[rf_addr] <= rf_wdata;
    end
  end

  int          rf_we_cnt = 0;
  logic [3:0]  we_addr;
  logic [31:0] we_data;
  always @(negedge clk) begin
    if (rf_we) begin
      rf_we_cnt++;
      we_addr = rf_addr;
      we_data = rf_wdata;
    end
  end

  // CSR responder: acks in the csr_lat-th cycle of csr_req (0 = never).
  int          csr_lat = 0;
  logic [31:0] csr_val = 32'h0;
  int          csr_cnt = 0;
  int          csr_hi  = 0;
  always @(negedge clk) begin
    if (csr_req) begin
      csr_cnt++;
      csr_hi  = csr_cnt;
      csr_ack = (csr_lat != 0) && (csr_cnt == csr_lat);
      csr_rdata = csr_ack ? csr_val : 32'h0;
    end else begin
      csr_cnt   = 0;
      csr_ack   = 1'b0;
      csr_rdata = 32'h0;
    end
  end

  // Response monitor: every presented response must match the head entry.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: rdata 0x%08h err %0d with no request pending", resp_rdata, resp_err);
      end else begin
        chk("resp_rdata", resp_rdata, sb[0].rdata);
        chk("resp_err", 32'(resp_err), 32'(sb[0].err));
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [12:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] erd, input logic [1:0] eerr);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    sb.push_back('{rdata: erd, err: eerr});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycles after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 400) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 600) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_reached", 32'(n < 600), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hold;
    int halt_hi;
    reset = 1'b1; debug_enable = 1'b1; cpu_halted = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    resp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_csr_req", 32'(csr_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // GPR read, core halted: response on the second edge counting the accept edge
    issue(13'h0005, 1'b0, 32'h0, 32'hDEADBEEF, 2'd0);
    chk("gpr_rd_rf_addr", 32'(rf_addr), 32'd5);
    chk("gpr_rd_halt_req", 32'(halt_req), 32'd1);
    wait_resp(n);
    chk("gpr_rd_latency", 32'(n + 1), 32'd2);
    wait_idle();

    // GPR write to x0 is suppressed, to x3 strobes once
    rf_we_cnt = 0;
    issue(13'h0000, 1'b1, 32'h12345678, 32'h0, 2'd0);
    wait_idle();
    chk("gpr_wr0_no_strobe", 32'(rf_we_cnt), 32'd0);
    issue(13'h0003, 1'b1, 32'h12345678, 32'h0, 2'd0);
    wait_idle();
    chk("gpr_wr3_strobes", 32'(rf_we_cnt), 32'd1);
    chk("gpr_wr3_addr", 32'(we_addr), 32'd3);
    chk("gpr_wr3_data", we_data, 32'h12345678);

    // CSR read 0x300, ack in 4th cycle
    csr_lat = 4; csr_val = 32'h1800;
    issue(13'h1300, 1'b0, 32'h0, 32'h1800, 2'd0);
    chk("csr_rd_req", 32'(csr_req), 32'd1);
    chk("csr_rd_addr", 32'(csr_addr), 32'h300);
    chk("csr_rd_we", 32'(csr_we), 32'd0);
    wait_resp(n);
    chk("csr_rd_req_cycles", 32'(csr_hi), 32'd4);
    wait_idle();

    // CSR write acked in its first cycle
    csr_lat = 1; csr_val = 32'hFFFF_FFFF;
    issue(13'h1305, 1'b1, 32'hA5A5_0001, 32'h0, 2'd0);
    chk("csr_wr_we", 32'(csr_we), 32'd1);
    chk("csr_wr_wdata", csr_wdata, 32'hA5A5_0001);
    wait_resp(n);
    chk("csr_wr_latency", 32'(n + 1), 32'd2);
    wait_idle();
    chk("halt_after_resp", 32'(halt_req), AUTO ? 32'd0 : 32'd1);

    // CSR never acks
    csr_lat = 0;
    issue(13'h1340, 1'b0, 32'h0, 32'h0, 2'd3);
    wait_resp(n);
    chk("csr_tmo_wait", 32'(n), 32'd255);
    chk("csr_tmo_req_cycles", 32'(csr_hi), 32'd255);
    chk("csr_tmo_req_dropped", 32'(csr_req), 32'd0);
    wait_idle();

    // debug_enable low parks the block and releases halt
    debug_enable = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("dis_halt_req", 32'(halt_req), 32'd0);
    chk("dis_req_ready", 32'(req_ready), 32'd0);
    debug_enable = 1'b1;
    @(posedge clk); #1;

    // Bad GPR index with 20 cycles of back-pressure; no halt
    resp_ready = 1'b0;
    halt_hi = 0;
    issue(13'h0014, 1'b0, 32'h0, 32'h0, 2'd1);
    hold = 0;
    repeat (20) begin
      if (resp_valid) hold++;
      if (halt_req) halt_hi++;
      @(posedge clk); #1;
    end
    chk("bad_hold_cycles", 32'(hold), 32'd20);
    chk("bad_no_halt", 32'(halt_hi), 32'd0);
    resp_ready = 1'b1;
    wait_idle();

    // Core never halts
    cpu_halted = 1'b0;
    issue(13'h0005, 1'b0, 32'h0, 32'h0, 2'd2);
    chk("halt_tmo_halt_req", 32'(halt_req), 32'd1);
    wait_resp(n);
    chk("halt_tmo_wait", 32'(n), 32'd255);
    wait_idle();

    // Core halts 10 cycles after accept
    issue(13'h0003, 1'b0, 32'h0, 32'h12345678, 2'd0);
    repeat (10) begin @(posedge clk); #1; end
    cpu_halted = 1'b1;
    wait_idle();

    // Reset in the middle of a CSR wait
    csr_lat = 0; rf_we_cnt = 0;
    issue(13'h1301, 1'b1, 32'h5555_AAAA, 32'h0, 2'd3);
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_csr_req", 32'(csr_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_csr_req", 32'(csr_req), 32'd0);
    chk("midrst_halt_req", 32'(halt_req), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("postrst_csr_req", 32'(csr_req), 32'd0);
    chk("postrst_no_write", 32'(rf_we_cnt), 32'd0);
    chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("postrst_req_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_access_ctrl.md
Name: debug_access_ctrl

Overview:
- Parametrised debug access controller between an external debug transport and the CPU core.
- Serialises external read/write requests into halt-protected accesses on dedicated GPR and CSR debug ports.
- Uses valid/ready handshakes on both sides, timeout-guarded waits and error-coded responses.
- Next-generation debug block: replaces direct array access with port-based, handshaked access.

Parameters:
- XLEN, 32, data width of GPRs, CSRs and debug data.
- NREG, 32, number of GPRs; GPR index width RW = $clog2(NREG).
- CSR_AW, 12, CSR address width; debug address width AW = CSR_AW+1.
- TMO_W, 8, timeout counter width; timeout limit = 2^TMO_W-1 cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- debug_enable  in  1  enables the block; 0 forces the FSM to IDLE at the next edge after any pending response.
- req_valid  in  1  request valid.
- req_ready  out  1  request accept; high only in IDLE with debug_enable=1.
- req_addr  in  AW  bit AW-1: 0=GPR space (index in [RW-1:0]), 1=CSR space (address in [CSR_AW-1:0]).
- req_write  in  1  1=write, 0=read.
- req_wdata  in  XLEN  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_rdata  out  XLEN  read data; 0 for writes and errors.
- resp_err  out  2  0=OK, 1=bad address, 2=halt timeout, 3=CSR timeout.
- halt_req  out  1  halt request to the core.
- cpu_halted  in  1  core halted acknowledge.
- rf_addr  out  RW  GPR debug port index.
- rf_we  out  1  GPR write strobe, single cycle.
- rf_wdata  out  XLEN  GPR write data.
- rf_rdata  in  XLEN  combinational GPR read data for rf_addr.
- csr_req  out  1  CSR access request; held until csr_ack.
- csr_we  out  1  CSR write qualifier.
- csr_addr  out  CSR_AW  CSR address.
- csr_wdata  out  XLEN  CSR write data.
- csr_rdata  in  XLEN  CSR read data, valid with csr_ack.
- csr_ack  in  1  CSR access complete.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0, request latches 0.
- FSM states: IDLE, HALT, GPR, CSR, RESP.
- IDLE:
  - On req_valid&req_ready, latch addr/write/wdata.
  - GPR index >= NREG: go to RESP with err=1 (no halt).
  - Otherwise assert halt_req. Go to GPR/CSR if cpu_halted is already 1, else go to HALT.
- HALT:
  - Counter increments each cycle.
  - cpu_halted=1: go to GPR or CSR, clear counter.
  - Counter reaches limit: go to RESP with err=2.
- GPR (exactly 1 cycle):
  - Drive rf_addr.
  - Write: rf_we=1 with rf_wdata. Index 0 suppresses rf_we; response is still OK.
  - Read: capture rf_rdata at the end of this cycle.
  - Then go to RESP.
- CSR:
  - Drive csr_req=1 with csr_we/addr/wdata stable until the ack cycle.
  - csr_ack: capture csr_rdata (reads only) and drop csr_req next cycle.
  - No ack by the timeout limit: drop csr_req, err=3.
- RESP:
  - resp_valid held with stable rdata/err until resp_ready; back-pressure is unlimited.
  - Handshake cycle: go to IDLE; resp_valid=0 on the next cycle.
- Latency with the core already halted: GPR access gives resp_valid 2 cycles after the accept edge. CSR with ack on its first cycle is also 2 cycles.
- halt_req:
  - Set at accept.
  - Without the macro, stays high until debug_enable=0 is seen in IDLE, or reset.
- debug_enable falling mid-transaction: the transaction completes; halt_req drops after the return to IDLE.
- req_valid during a non-IDLE state: ignored (req_ready=0); no queuing.
- Reset mid-transaction: immediate return to reset values; no partial write is issued after reset deasserts.

Optional Feature:
- Macro DBG_AUTO_RESUME_EN.
- Defined: halt_req is released in the same cycle as the RESP handshake, so each access is individually halt/resume bracketed. The next accept re-asserts halt_req and waits for cpu_halted again.
- Undefined: sticky halt as described in Behaviour.

Decomposition:
- Package dbg_pkg holds:
  - FSM state enum.
  - Error code constants: DBG_OK, DBG_EBADADDR, DBG_EHALT, DBG_ECSR.
  - Address space select bit position constant.
- One sub-module, dbg_timeout_ctr: clear/enable inputs, expired output, parametrised by TMO_W; one instance shared by HALT and CSR.

Test Plan:
- Core halted, GPR read: idx 5 holds 0xDEADBEEF -> rf_addr=5, resp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
- GPR write of 0x12345678 to idx 0 -> rf_we stays 0 and err=0. Same write to idx 3 -> one-cycle rf_we with rf_wdata=0x12345678.
- CSR read 0x300 with ack after 4 cycles (csr_rdata=0x1800) -> csr_req high 4 cycles, rdata=0x1800. CSR with no ack -> err=3 after 255 cycles, csr_req drops.
- cpu_halted held 0 -> halt_req=1, err=2 after 255 cycles. cpu_halted raised at cycle 10 -> access proceeds, err=0.
- NREG=16, GPR idx 20 -> err=1, halt_req never asserted. resp_ready held low 20 cycles -> resp_valid/rdata/err stable throughout.
- Reset asserted during the CSR wait -> csr_req, halt_req, resp_valid low immediately. With DBG_AUTO_RESUME_EN, halt_req drops on the response handshake; without it, halt_req drops only after debug_enable=0.
